shift_register_tx: RTL and testbench
====================================

Name: shift_register_tx

Overview:
Transmit-side serializer for the self-defined UART core, the TX counterpart of the receive shift register. Accepts a parallel byte via valid/ready handshake, then drives start bit, data bits LSB-first, optional parity and stop bit(s) onto the TX line, one bit per baud tick. Sits between the TX FIFO/host interface and the pad. Also drives the shared baudrate module's resync pulse and exports its one-hot state.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (5..8 legal)
STOP_BITS, 1, number of stop bits (1 or 2 legal)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
BaudSig_i  input  1  one-cycle baud tick from baudrate module, one per bit period
Data_i  input  DATA_WIDTH  byte to send, sampled on accept
Valid_i  input  1  Data_i valid
Ready_o  output  1  block can accept a byte this cycle
ParityOdd_i  input  1  1 = odd parity, 0 = even; used only with TX_PARITY_EN
Tx_o  output  1  serial line, idle high
Tx_Synch_o  output  1  one-cycle pulse on accept; restarts baudrate counter
State_o  output  5  one-hot FSM state
BitCounter_o  output  3  index of data bit currently on line
Done_o  output  1  one-cycle pulse when last stop bit completes

Behaviour:
- Reset is synchronous and active-high on clk. Single clock domain.
- Reset values: State_o=IDLE (5'b0_0001), Tx_o=1, Ready_o=1, Tx_Synch_o=0, Done_o=0, BitCounter_o=0, data and parity registers 0.
- State encodings: IDLE=5'b0_0001, STARTBIT=5'b0_0010, DATABITS=5'b0_0100, PARITYBIT=5'b0_1000, STOPBIT=5'b1_0000.
- Ready_o is combinational: (State==IDLE).
- Accept occurs when Valid_i & Ready_o:
  - latch Data_i into the shift register;
  - Tx_Synch_o=1 in the same cycle;
  - next cycle State=STARTBIT and Tx_o=0.
- BaudSig_i in IDLE is ignored. If accept and BaudSig_i occur in the same cycle, accept wins and the tick is ignored.
- Each bit state lasts until the next BaudSig_i. The baud module is restarted by Tx_Synch_o, so every bit, including the start bit, lasts one full bit period.
- STARTBIT + tick → DATABITS:
  - Tx_o=shift[0];
  - BitCounter=0.
- DATABITS + tick:
  - if BitCounter==DATA_WIDTH-1 → PARITYBIT (when enabled) or STOPBIT;
  - else shift right, BitCounter+1, Tx_o=next LSB.
- PARITYBIT + tick → STOPBIT, Tx_o=1.
- STOPBIT + tick:
  - with STOP_BITS=2, the first tick stays in STOPBIT (internal stop counter);
  - on the last tick → IDLE and Done_o=1 for one cycle. Ready_o is high in that same next cycle.
- Tx_o is registered and glitch-free, driven 1 in IDLE, PARITYBIT-exit and STOPBIT.
- Back-to-back frames: if Valid_i is held, the next accept happens in the first IDLE cycle. The gap is 1 clk plus the baud restart.
- Valid_i or Data_i changing outside IDLE has no effect; the latched byte is used.
- Reset mid-frame: next cycle State=IDLE, Tx_o=1, and no Done_o pulse.
- Unused BitCounter bits for DATA_WIDTH<8 read 0.

Optional Feature:
TX_PARITY_EN
- Defined:
  - parity = ^Data (even) or ~^Data (odd, per ParityOdd_i), computed at accept and held;
  - PARITYBIT state is entered after the last data bit, and Tx_o=parity for one bit period.
- Undefined:
  - PARITYBIT is never entered: DATABITS goes directly to STOPBIT;
  - ParityOdd_i is ignored;
  - State_o bit 3 is constant 0.

Test Plan:
1. Reset, then Valid_i=1, Data_i=8'hA5, no parity → Tx_Synch_o pulse at accept. Tx_o per bit period: 0,1,0,1,0,0,1,0,1,1. Done_o pulses once; Ready_o=1 after.
2. TX_PARITY_EN, Data_i=8'hA5 → parity bit 0 with ParityOdd_i=0 and 1 with ParityOdd_i=1, placed between the 8th data bit and the stop bit.
3. STOP_BITS=2, Data_i=8'h00 → start + 8 zeros, then 2 high bit periods before Done_o. State_o=5'b1_0000 spans 2 ticks.
4. Valid_i held high with Data_i=8'h55 then 8'hAA → two frames. Second accept occurs in the first IDLE cycle after Done_o. Data_i changes mid-frame don't corrupt frame 1.
5. Assert rst during DATABITS (BitCounter=3) → next cycle Tx_o=1, State_o=5'b0_0001, BitCounter_o=0. No Done_o. A new accept works normally.
6. BaudSig_i pulses while idle, plus BaudSig_i coincident with accept → Tx_o stays 1 in idle. The coincident tick does not shorten the start bit (start bit = full period).

Source files
------------

// File: rtl/shift_register_tx.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Define TX_PARITY_EN to insert a parity bit between the last data bit and the stop bit(s).
module shift_register_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  BaudSig_i,
    input  logic [DATA_WIDTH-1:0] Data_i,
    input  logic                  Valid_i,
    output logic                  Ready_o,
    input  logic                  ParityOdd_i,
    output logic                  Tx_o,
    output logic                  Tx_Synch_o,
    output logic [4:0]            State_o,
    output logic [2:0]            BitCounter_o,
    output logic                  Done_o
);

    // state     | meaning
    // IDLE      | line high, waiting for a byte
    // STARTBIT  | driving start bit (0)
    // DATABITS  | driving data bits LSB-first
    // PARITYBIT | driving parity bit (TX_PARITY_EN only)
    // STOPBIT   | driving stop bit(s) (1)
    typedef enum logic [4:0] {
        IDLE      = 5'b0_0001,
        STARTBIT  = 5'b0_0010,
        DATABITS  = 5'b0_0100,
        PARITYBIT = 5'b0_1000,
        STOPBIT   = 5'b1_0000
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);
    localparam bit         TWO_STOP = (STOP_BITS == 2);

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
    logic [2:0]            bit_cnt_q, bit_cnt_nxt;
    logic                  stop_cnt_q, stop_cnt_nxt;
    logic                  tx_q, tx_nxt;
    logic                  done_q, done_nxt;
    logic                  accept;

`ifdef TX_PARITY_EN
    logic parity_q, parity_nxt;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = ParityOdd_i;
`endif

    assign Ready_o = (state == IDLE);
    assign accept  = Valid_i & Ready_o & ~rst;

    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift_q;
        bit_cnt_nxt  = bit_cnt_q;
        stop_cnt_nxt = stop_cnt_q;
        tx_nxt       = tx_q;
        done_nxt     = 1'b0;
`ifdef TX_PARITY_EN
        parity_nxt   = parity_q;
`endif
        case (state)
            IDLE: begin
                // Baud ticks are ignored here; accept also wins over a coincident tick.
                tx_nxt = 1'b1;
                if (accept) begin
                    shift_nxt    = Data_i;
                    bit_cnt_nxt  = 3'd0;
                    stop_cnt_nxt = 1'b0;
                    tx_nxt       = 1'b0;
                    state_nxt    = STARTBIT;
`ifdef TX_PARITY_EN
                    parity_nxt   = (^Data_i) ^ ParityOdd_i;
`endif
                end
            end
            STARTBIT: begin
                if (BaudSig_i) begin
                    state_nxt   = DATABITS;
                    tx_nxt      = shift_q[0];
                    bit_cnt_nxt = 3'd0;
                end
            end
            DATABITS: begin
                if (BaudSig_i) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef TX_PARITY_EN
                        state_nxt = PARITYBIT;
                        tx_nxt    = parity_q;
`else
                        state_nxt = STOPBIT;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        shift_nxt   = shift_q >> 1;
                        bit_cnt_nxt = bit_cnt_q + 3'd1;
                        tx_nxt      = shift_q[1];
                    end
                end
            end
            PARITYBIT: begin
                if (BaudSig_i) begin
                    state_nxt = STOPBIT;
                    tx_nxt    = 1'b1;
                end
            end
            STOPBIT: begin
                tx_nxt = 1'b1;
                if (BaudSig_i) begin
                    if (TWO_STOP && !stop_cnt_q) begin
                        stop_cnt_nxt = 1'b1;
                    end else begin
                        stop_cnt_nxt = 1'b0;
                        state_nxt    = IDLE;
                        done_nxt     = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
`ifdef TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            shift_q    <= shift_nxt;
            bit_cnt_q  <= bit_cnt_nxt;
            stop_cnt_q <= stop_cnt_nxt;
            tx_q       <= tx_nxt;
            done_q     <= done_nxt;
`ifdef TX_PARITY_EN
            parity_q   <= parity_nxt;
`endif
        end
    end

    assign Tx_o         = tx_q;
    assign Tx_Synch_o   = accept;
    assign State_o      = state;
    assign BitCounter_o = bit_cnt_q;
    assign Done_o       = done_q;

endmodule

// File: tb/tb_shift_register_tx.sv
// Bench for shift_register_tx: table-driven and randomized frames on an 8N1 and a 5-bit/2-stop instance,
// plus hand-written idle-tick and mid-frame reset sequences. Honours TX_PARITY_EN when defined.
module tb_shift_register_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       valid = 1'b0;
    logic       parity_odd = 1'b0;
    logic       sel = 1'b0;

    logic       ready_a, tx_a, synch_a, done_a, ready_b, tx_b, synch_b, done_b;
    logic [4:0] state_a, state_b;
    logic [2:0] cnt_a, cnt_b;
    logic       ready_s, tx_s, synch_s, done_s;
    logic [4:0] state_s;
    logic [2:0] cnt_s;

    int total = 0;
    int bad = 0;
    int dw = 8, sb = 1, p = 4;
    logic odd_cur = 1'b0;
    logic exp_q[$];

`ifdef TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    shift_register_tx #(.DATA_WIDTH(8), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .BaudSig_i(baud), .Data_i(data_i), .Valid_i(valid & ~sel),
        .Ready_o(ready_a), .ParityOdd_i(parity_odd), .Tx_o(tx_a), .Tx_Synch_o(synch_a),
        .State_o(state_a), .BitCounter_o(cnt_a), .Done_o(done_a)
    );

    shift_register_tx #(.DATA_WIDTH(5), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .BaudSig_i(baud), .Data_i(data_i[4:0]), .Valid_i(valid & sel),
        .Ready_o(ready_b), .ParityOdd_i(parity_odd), .Tx_o(tx_b), .Tx_Synch_o(synch_b),
        .State_o(state_b), .BitCounter_o(cnt_b), .Done_o(done_b)
    );

    assign ready_s = sel ? ready_b : ready_a;
    assign tx_s    = sel ? tx_b    : tx_a;
    assign synch_s = sel ? synch_b : synch_a;
    assign done_s  = sel ? done_b  : done_a;
    assign state_s = sel ? state_b : state_a;
    assign cnt_s   = sel ? cnt_b   : cnt_a;

    typedef struct {
        logic [7:0] data;
        logic       odd;
        bit         coincide;
        bit         hold;
        logic [9:0] line;   // expected line without parity, bit 0 first on the wire
    } vec_t;

    task automatic check(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s got=%0h expected=%0h", tag, name, act, exp);
        end
    endtask

    task automatic select_dut(input logic s);
        sel = s;
        dw  = s ? 5 : 8;
        sb  = s ? 2 : 1;
        p   = s ? 3 : 4;
    endtask

    function automatic logic par(input logic [7:0] d, input logic odd);
        int ones = 0;
        for (int i = 0; i < dw; i++) ones += int'(d[i]);
        return logic'(ones % 2) ^ odd;
    endfunction

    // Reference frame: start 0, dw data bits LSB first, optional parity, sb stop bits of 1.
    task automatic build_model(input logic [7:0] d);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < dw; i++) exp_q.push_back(d[i]);
        if (PAR_EN) exp_q.push_back(par(d, odd_cur));
        for (int i = 0; i < sb; i++) exp_q.push_back(1'b1);
    endtask

    function automatic logic [4:0] exp_state(input int i);
        if (i == 0) return 5'b0_0010;
        if (i <= dw) return 5'b0_0100;
        if (PAR_EN && i == dw + 1) return 5'b0_1000;
        return 5'b1_0000;
    endfunction

    // Sends one frame whose expected line is in exp_q; ends on the cycle carrying the final stop tick.
    task automatic frame(input logic [7:0] d, input logic odd, input bit coincide, input bit hold,
                         input logic [7:0] next_d, input bit after_frame, input string tag);
        logic tx_got;
        bit   ctl_err;
        @(posedge clk); #1;
        data_i = d; valid = 1'b1; parity_odd = odd; baud = coincide;
        @(negedge clk);
        check(tag, "accept_ready", ready_s, 1);
        check(tag, "accept_synch", synch_s, 1);
        if (after_frame) check(tag, "b2b_done_at_accept", done_s, 1);
        for (int i = 0; i < exp_q.size(); i++) begin
            tx_got  = exp_q[i];
            ctl_err = 1'b0;
            for (int k = 0; k < p; k++) begin
                @(posedge clk); #1;
                baud       = (k == p - 1);
                valid      = hold;
                data_i     = hold ? next_d : 8'($urandom);
                parity_odd = 1'($urandom);
                @(negedge clk);
                if (tx_s !== exp_q[i]) tx_got = tx_s;
                if (state_s !== exp_state(i) || done_s !== 1'b0 || synch_s !== 1'b0 || ready_s !== 1'b0)
                    ctl_err = 1'b1;
                if (exp_state(i) == 5'b0_0100 && cnt_s !== 3'(i - 1)) ctl_err = 1'b1;
            end
            check(tag, $sformatf("tx_bit%0d", i), tx_got, exp_q[i]);
            check(tag, $sformatf("ctl_bit%0d", i), ctl_err, 0);
        end
    endtask

    task automatic done_check(input string tag);
        @(posedge clk); #1;
        baud = 1'b0; valid = 1'b0;
        @(negedge clk);
        check(tag, "done_pulse", done_s, 1);
        check(tag, "done_ready", ready_s, 1);
        check(tag, "done_state", state_s, 5'b0_0001);
        check(tag, "done_tx", tx_s, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check(tag, "done_single", done_s, 0);
    endtask

    task automatic run_random(input int n, input string tag);
        logic [7:0] d, nd;
        bit         hold, prev_hold;
        prev_hold = 1'b0;
        d = 8'($urandom);
        for (int i = 0; i < n; i++) begin
            hold    = (i < n - 1) && ($urandom_range(0, 2) == 0);
            nd      = 8'($urandom);
            odd_cur = 1'($urandom);
            build_model(d);
            frame(d, odd_cur, 1'($urandom), hold, nd, prev_hold, tag);
            if (!hold) done_check(tag);
            prev_hold = hold;
            d = nd;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[8];
        bit         ctl_err;
        logic [7:0] nd;

        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10'h34A};
        tbl[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 10'h34A};
        tbl[2] = '{8'h55, 1'b0, 1'b0, 1'b1, 10'h2AA};
        tbl[3] = '{8'hAA, 1'b1, 1'b0, 1'b0, 10'h354};
        tbl[4] = '{8'h00, 1'b0, 1'b1, 1'b0, 10'h200};
        tbl[5] = '{8'hFF, 1'b1, 1'b0, 1'b1, 10'h3FE};
        tbl[6] = '{8'h01, 1'b0, 1'b1, 1'b0, 10'h202};
        tbl[7] = '{8'h80, 1'b1, 1'b0, 1'b0, 10'h300};

        // Reset state of both instances.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            select_dut(1'(s));
            #1;
            check("reset", "state", state_s, 5'b0_0001);
            check("reset", "tx", tx_s, 1);
            check("reset", "ready", ready_s, 1);
            check("reset", "synch", synch_s, 0);
            check("reset", "done", done_s, 0);
            check("reset", "cnt", cnt_s, 0);
        end
        select_dut(1'b0);

        // Table-driven frames on the 8N1 instance.
        for (int i = 0; i < 8; i++) begin
            exp_q.delete();
            for (int b = 0; b < 9; b++) exp_q.push_back(tbl[i].line[b]);
            if (PAR_EN) begin
                odd_cur = tbl[i].odd;
                exp_q.push_back(par(tbl[i].data, tbl[i].odd));
            end
            exp_q.push_back(tbl[i].line[9]);
            nd = (i < 7) ? tbl[i + 1].data : 8'h00;
            frame(tbl[i].data, tbl[i].odd, tbl[i].coincide, tbl[i].hold, nd,
                  (i > 0) && tbl[i - 1].hold, $sformatf("tbl%0d", i));
            if (!tbl[i].hold) done_check($sformatf("tbl%0d", i));
        end

        // Baud ticks while idle leave the line high and the FSM in IDLE.
        ctl_err = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            baud = ~k[0];
            @(negedge clk);
            if (tx_s !== 1'b1 || state_s !== 5'b0_0001 || done_s !== 1'b0) ctl_err = 1'b1;
        end
        baud = 1'b0;
        check("idle_baud", "stays_idle", ctl_err, 0);

        run_random(12, "rnd_a");

        // Reset during data bit 3.
        @(posedge clk); #1;
        data_i = 8'hC3; valid = 1'b1; baud = 1'b0;
        @(negedge clk);
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < p; k++) begin
                @(posedge clk); #1;
                valid = 1'b0;
                baud  = (k == p - 1);
            end
        end
        @(posedge clk); #1;
        baud = 1'b0;
        @(negedge clk);
        check("midrst", "pre_cnt", cnt_s, 3);
        check("midrst", "pre_state", state_s, 5'b0_0100);
        check("midrst", "pre_tx", tx_s, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst", "state", state_s, 5'b0_0001);
        check("midrst", "tx", tx_s, 1);
        check("midrst", "cnt", cnt_s, 0);
        ctl_err = (done_s !== 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (done_s !== 1'b0 || state_s !== 5'b0_0001) ctl_err = 1'b1;
        end
        check("midrst", "no_done", ctl_err, 0);
        odd_cur = 1'b0;
        build_model(8'h3C);
        frame(8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "post_rst");
        done_check("post_rst");

        // 5-bit, 2-stop instance: all-zero frame, then random traffic.
        select_dut(1'b1);
        odd_cur = 1'b0;
        build_model(8'h00);
        frame(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "b_zero");
        done_check("b_zero");
        run_random(10, "rnd_b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
